// File: rtl/imm_ext_arbiter.sv
// ---------------------------------------------------------------------------
// imm_ext_arbiter
//
// Purpose:
//   Shares one immediate-extension datapath between two requesters:
//   req0 (decode) and req1 (branch/jump target unit). Requests are
//   arbitrated round-robin. The selected immediate is extended in one of four
//   modes, and the result is held in a one-entry output register that has a
//   valid/ready handshake. The block sits between the decode stage and the
//   ALU/PC operand muxes.
//
// Handshake:
//   A transfer happens on a rising edge where valid and ready are both high.
//   Each reqN_ready is a pure function of the slot state, both valids and the
//   round-robin pointer. It is never a registered echo of its own valid.
//   The output side follows the same rule: a result leaves when
//   out_valid && out_ready. A new result can refill the slot on the same edge.
//
// Parameters:
//   SIZE_IN   width of the raw immediate field
//   SIZE_OUT  width of the extended result (must be >= SIZE_IN+2)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req0_valid/ready      requester 0 handshake
//   req0_imm, req0_mode   requester 0 immediate and extension mode
//   req1_valid/ready      requester 1 handshake
//   req1_imm, req1_mode   requester 1 immediate and extension mode
//   out_valid/ready       result handshake
//   out_data              extended result
//   out_src               requester that produced out_data
//   prio_state            current round-robin pointer (debug/observability)
// ---------------------------------------------------------------------------
module imm_ext_arbiter #(
    parameter int SIZE_IN  = 16,
    parameter int SIZE_OUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [SIZE_IN-1:0]  req0_imm,
    input  logic [1:0]          req0_mode,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [SIZE_IN-1:0]  req1_imm,
    input  logic [1:0]          req1_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE_OUT-1:0] out_data,
    output logic                out_src,
    output logic                prio_state
);

    localparam int PAD = SIZE_OUT - SIZE_IN;

    // Extension modes:
    //   00 sign-extend
    //   01 zero-extend
    //   10 sign-extend, then shift left by 2
    //   11 place the immediate in the upper bits
    function automatic logic [SIZE_OUT-1:0] extend(input logic [SIZE_IN-1:0] a,
                                                   input logic [1:0]         mode);
        logic [SIZE_OUT-1:0] sext;
        logic [SIZE_OUT-1:0] res;
        sext = {{PAD{a[SIZE_IN-1]}}, a};
        case (mode)
            2'b00:   res = sext;
            2'b01:   res = {{PAD{1'b0}}, a};
            2'b10:   res = sext << 2;  // upper bits fall off the top
            default: res = {a, {PAD{1'b0}}};
        endcase
        extend = res;
    endfunction

    logic                prio;  // requester favoured when both are valid
    logic                free;
    logic                grant0;
    logic                grant1;
    logic [SIZE_IN-1:0]  win_imm;
    logic [1:0]          win_mode;
    logic [SIZE_OUT-1:0] ext_result;

    always_comb begin
        free   = !out_valid || out_ready;
        grant0 = 1'b0;
        grant1 = 1'b0;
        // Gating with rst keeps both readys low for every reset cycle,
        // including the cycle before the register has actually cleared.
        if (free && !rst) begin
            if (req0_valid && req1_valid) begin
                grant0 = !prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        win_imm    = grant1 ? req1_imm  : req0_imm;
        win_mode   = grant1 ? req1_mode : req0_mode;
        ext_result = extend(win_imm, win_mode);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign prio_state = prio;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            prio      <= 1'b0;
        end else if (grant0 || grant1) begin
            out_data  <= ext_result;
            out_src   <= grant1;
            out_valid <= 1'b1;
            prio      <= !grant1;  // hand priority to the other requester
        end else if (free) begin
            // No refill this cycle. Drop valid if the held result was taken.
            // out_data keeps its last value.
            out_valid <= out_valid && !out_ready;
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
module tb_imm_ext_arbiter;

    localparam int SI = 16;
    localparam int SO = 32;

    logic          clk;
    logic          rst;
    logic          req0_valid;
    logic          req0_ready;
    logic [SI-1:0] req0_imm;
    logic [1:0]    req0_mode;
    logic          req1_valid;
    logic          req1_ready;
    logic [SI-1:0] req1_imm;
    logic [1:0]    req1_mode;
    logic          out_valid;
    logic          out_ready;
    logic [SO-1:0] out_data;
    logic          out_src;
    logic          prio_state;

    imm_ext_arbiter #(.SIZE_IN(SI), .SIZE_OUT(SO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .prio_state (prio_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Each queue entry is {src, data}.
    logic [SO:0] exp_q[$];

    // Model state. It is updated at negedge and read by the driver.
    bit m_valid  = 0;
    bit m_prio   = 0;
    bit acc0     = 0;
    bit acc1     = 0;
    bit rst_prev = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension. It uses plain integer arithmetic on the immediate's value.
    function automatic logic [SO-1:0] model_ext(input logic [SI-1:0] a, input logic [1:0] m);
        longint      v;
        logic [63:0] t;
        v = longint'(a);
        if (v >= 32768) v = v - 65536;  // two's-complement value of a
        case (m)
            2'd0:    t = 64'(v);
            2'd1:    t = 64'(longint'(a));
            2'd2:    t = 64'(v * 4);
            default: t = 64'(longint'(a) * 65536);
        endcase
        return t[SO-1:0];
    endfunction

    // ---------------- reference model + ready/valid checks ----------------
    always @(negedge clk) begin
        bit free;
        bit g0;
        bit g1;
        if (rst) begin
            chk("ready0_in_reset", 64'(req0_ready), 64'd0);
            chk("ready1_in_reset", 64'(req1_ready), 64'd0);
            if (rst_prev) begin
                chk("reset_out_valid", 64'(out_valid), 64'd0);
                chk("reset_out_data",  64'(out_data),  64'd0);
                chk("reset_out_src",   64'(out_src),   64'd0);
            end
            m_valid = 0;
            m_prio  = 0;
            acc0    = 0;
            acc1    = 0;
            exp_q.delete();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("prio", 64'(prio_state), 64'(m_prio));
            free = !m_valid || out_ready;
            g0 = 0;
            g1 = 0;
            if (free) begin
                if (req0_valid && req1_valid) begin
                    if (m_prio) g1 = 1;
                    else        g0 = 1;
                end else if (req0_valid) begin
                    g0 = 1;
                end else if (req1_valid) begin
                    g1 = 1;
                end
            end
            chk("req0_ready", 64'(req0_ready), 64'(g0));
            chk("req1_ready", 64'(req1_ready), 64'(g1));
            if (g0) exp_q.push_back({1'b0, model_ext(req0_imm, req0_mode)});
            if (g1) exp_q.push_back({1'b1, model_ext(req1_imm, req1_mode)});
            if (g0 || g1) begin
                m_valid = 1;
                m_prio  = g0;  // the other requester is favoured next
            end else if (free) begin
                m_valid = 0;
            end
            acc0 = g0;
            acc1 = g1;
        end
        rst_prev = rst;
    end

    // ---------------- monitor / scoreboard ----------------
    // The head entry is compared on every valid cycle. This also checks that
    // the output stays stable under backpressure. The entry is popped only when
    // out_ready is high, so it is consumed at the next edge.
    always @(negedge clk) begin
        logic [SO:0] e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'(out_data), 64'hDEAD);
            end else begin
                e = exp_q[0];
                chk("out_data", 64'(out_data), 64'(e[SO-1:0]));
                chk("out_src",  64'(out_src),  64'(e[SO]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    // A requester that was not accepted keeps valid, imm and mode stable.
    task automatic drive(input bit v0, input logic [SI-1:0] i0, input logic [1:0] m0,
                         input bit v1, input logic [SI-1:0] i1, input logic [1:0] m1,
                         input bit ordy);
        @(posedge clk);
        #1;
        if (!(req0_valid && !acc0)) begin
            req0_valid = v0;
            req0_imm   = i0;
            req0_mode  = m0;
        end
        if (!(req1_valid && !acc1)) begin
            req1_valid = v1;
            req1_imm   = i1;
            req1_mode  = m1;
        end
        out_ready = ordy;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [SI-1:0] rimm();
        return SI'($urandom_range(0, 65535));
    endfunction

    function automatic logic [1:0] rmode();
        return 2'($urandom_range(0, 3));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_imm   = '0;
        req0_mode  = '0;
        req1_valid = 1'b0;
        req1_imm   = '0;
        req1_mode  = '0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // All four modes through req0, using the same immediate.
        for (int m = 0; m < 4; m++) drive(1, 16'h8001, 2'(m), 0, '0, '0, 1);
        drive(0, '0, '0, 0, '0, '0, 1);

        // Both requesters active, with continuous consume.
        for (int i = 0; i < 12; i++) drive(1, rimm(), rmode(), 1, rimm(), rmode(), 1);
        drive(0, '0, '0, 0, '0, '0, 1);

        // Backpressure: a result is held while req1 waits, then accepted.
        drive(1, rimm(), rmode(), 0, '0, '0, 0);
        for (int i = 0; i < 5; i++) drive(0, '0, '0, 1, 16'h1234, 2'b00, 0);
        drive(0, '0, '0, 1, 16'h1234, 2'b00, 1);

        // Consume and refill on the same edge.
        drive(0, '0, '0, 1, 16'h0003, 2'b10, 1);

        // Only req1 after alternation. Finish by showing prio returned to req0.
        for (int i = 0; i < 5; i++) drive(0, '0, '0, 1, rimm(), rmode(), 1);
        drive(1, rimm(), rmode(), 1, rimm(), rmode(), 1);
        drive(0, '0, '0, 0, '0, '0, 1);

        // Reset in the middle of a transfer. The first grant after reset goes to req0.
        drive(0, '0, '0, 1, rimm(), rmode(), 0);
        drive(1, rimm(), rmode(), 1, rimm(), rmode(), 0);
        do_reset(2);
        drive(1, rimm(), rmode(), 1, rimm(), rmode(), 1);
        drive(0, '0, '0, 0, '0, '0, 1);
        drive(0, '0, '0, 0, '0, '0, 1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), rimm(), rmode(),
                  1'($urandom_range(0, 1)), rimm(), rmode(),
                  ($urandom_range(0, 3) != 0));

        // Drain.
        for (int i = 0; i < 6; i++) drive(0, '0, '0, 0, '0, '0, 1);
        @(negedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
